// File: rtl/aes128_iter_enc_if.sv
// Block-level handshake bundle for the iterative AES-128 encryptor:
// plaintext/key in on one valid/ready pair, ciphertext out on another.
interface aes128_iter_enc_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] pt;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ct;
  logic         busy;

  modport master (output in_valid, pt, key, out_ready,
                  input  in_ready, out_valid, ct, busy);
  modport slave  (input  in_valid, pt, key, out_ready,
                  output in_ready, out_valid, ct, busy);
endinterface

// File: rtl/aes128_iter_enc.sv
// Iterative AES-128 encryptor with on-the-fly key expansion; UNROLL rounds are
// chained combinationally per clock, one block in flight at a time.
module aes128_iter_enc #(
  parameter int UNROLL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  aes128_iter_enc_if.slave  bus
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
    $error("aes128_iter_enc: UNROLL must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes and ShiftRows fused: output byte (row r, col c) takes input col c+r.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8 * (4 * c + r) -: 8] = sbox(s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32 * c -: 8];
      a1 = s[119 - 32 * c -: 8];
      a2 = s[111 - 32 * c -: 8];
      a3 = s[103 - 32 * c -: 8];
      o[127 - 32 * c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                               xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  function automatic logic [127:0] key_step(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(rk[23:16]) ^ rcon, sbox(rk[15:8]), sbox(rk[7:0]), sbox(rk[31:24])};
    w0 = rk[127:96] ^ t;
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_t       state_reg, state_next;
  logic [127:0] st_reg, rk_reg, ct_reg;
  logic [7:0]   rcon_reg;
  logic [3:0]   round_cnt_reg;

  logic [127:0] st_next, rk_next, sr_tmp;
  logic [7:0]   rcon_next;
  logic         accept, last_step;

  assign accept    = (state_reg == IDLE) && bus.in_valid;
  assign last_step = (round_cnt_reg + 4'(UNROLL)) == 4'd10;

  // Round chain; MixColumns is bypassed only in the round that lands on round 10.
  always_comb begin
    st_next   = st_reg;
    rk_next   = rk_reg;
    rcon_next = rcon_reg;
    sr_tmp    = '0;
    for (int i = 0; i < UNROLL; i++) begin
      sr_tmp    = sub_shift(st_next);
      rk_next   = key_step(rk_next, rcon_next);
      st_next   = (((round_cnt_reg + 4'(i)) == 4'd9) ? sr_tmp : mix_columns(sr_tmp)) ^ rk_next;
      rcon_next = xtime(rcon_next);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_reg)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_reg        <= '0;
      rk_reg        <= '0;
      rcon_reg      <= '0;
      round_cnt_reg <= '0;
      ct_reg        <= '0;
    end else if (accept) begin
      st_reg        <= bus.pt ^ bus.key;
      rk_reg        <= bus.key;
      rcon_reg      <= 8'h01;
      round_cnt_reg <= '0;
    end else if (state_reg == RUN) begin
      st_reg        <= st_next;
      rk_reg        <= rk_next;
      rcon_reg      <= rcon_next;
      round_cnt_reg <= round_cnt_reg + 4'(UNROLL);
      if (last_step) ct_reg <= st_next;
    end
  end

  assign bus.ct = ct_reg;

endmodule
